mux_n_pipe: RTL and testbench

- Parametrised N:1 select mux with a registered, elastic output stage.
- Generalises the fixed-width 4:1 register-number mux to any data width and input count.
- Adds a valid/ready handshake with a 2-entry skid buffer, so it can sit between pipeline stages (e.g. forwarding-source select into EX) without breaking timing on the ready path.
- Latency is one cycle; throughput is one beat per cycle.

---
 rtl/mux_n_pipe.sv | 129 ++++++++++++
 tb/tb_mux_n_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: parametrised N:1 select mux feeding a 2-entry elastic (main + skid) output stage.
// Optional build macro SEL_RANGE_CHECK_EN carries an out-of-range-select flag with each beat on sel_err.
module mux_n_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH*NUM_IN-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] mux_val;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             s_valid;
    logic             rdy_q;
    logic             acc;
    logic             pop;
    logic             ld_m_in;
    logic             ld_m_skid;
    logic             ld_s;
    logic             m_valid_nxt;
    logic             s_valid_nxt;

    // Selects outside 0..NUM_IN-1 match no input and leave the result at zero.
    always_comb begin
        mux_val = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(sel) == i) begin
                mux_val = din[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        acc         = in_valid & rdy_q;
        pop         = m_valid & out_ready;
        ld_m_in     = 1'b0;
        ld_m_skid   = 1'b0;
        ld_s        = 1'b0;
        m_valid_nxt = m_valid;
        s_valid_nxt = s_valid;
        if (!m_valid) begin
            if (acc) begin
                ld_m_in     = 1'b1;
                m_valid_nxt = 1'b1;
            end
        end else if (pop) begin
            if (s_valid) begin
                ld_m_skid   = 1'b1;
                s_valid_nxt = 1'b0;
            end else if (acc) begin
                ld_m_in = 1'b1;
            end else begin
                m_valid_nxt = 1'b0;
            end
        end else if (acc) begin
            ld_s        = 1'b1;
            s_valid_nxt = 1'b1;
        end
    end

    // rdy_q tracks !s_valid one flop early so in_ready has no path from out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
            m_data  <= '0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_nxt;
            s_valid <= s_valid_nxt;
            rdy_q   <= !s_valid_nxt;
            if (ld_m_in) begin
                m_data <= mux_val;
            end else if (ld_m_skid) begin
                m_data <= s_data;
            end
            if (ld_s) begin
                s_data <= mux_val;
            end
        end
    end

`ifdef SEL_RANGE_CHECK_EN
    logic sel_oob;
    logic m_err;
    logic s_err;

    always_comb begin
        sel_oob = (32'(sel) >= NUM_IN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_err <= 1'b0;
            s_err <= 1'b0;
        end else begin
            if (ld_m_in) begin
                m_err <= sel_oob;
            end else if (ld_m_skid) begin
                m_err <= s_err;
            end
            if (ld_s) begin
                s_err <= sel_oob;
            end
        end
    end

    assign sel_err = m_err;
`else
    assign sel_err = 1'b0;
`endif

    assign in_ready  = rdy_q;
    assign out_data  = m_data;
    assign out_valid = m_valid;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe: directed scenarios plus random valid/ready stress
// against a queue-based reference model (4-input/32-bit and 3-input/16-bit instances).
module tb_mux_n_pipe;

`ifdef SEL_RANGE_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } beat_t;

    logic         clk;
    logic         reset;
    logic [127:0] din;
    logic [47:0]  din3;
    logic [1:0]   sel;
    logic         in_valid;
    logic         out_ready;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         sel_err;
    logic         in_ready3;
    logic [15:0]  out_data3;
    logic         out_valid3;
    logic         sel_err3;

    int checks = 0;
    int errors = 0;

    beat_t q4[$];
    beat_t q3[$];

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .din(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_n_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .din(din3), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready), .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref4(input logic [127:0] d, input int unsigned s);
        if (s >= 4) return '0;
        return 32'((d >> (s * 32)) & 128'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref3(input logic [47:0] d, input int unsigned s);
        if (s >= 3) return '0;
        return 32'((d >> (s * 16)) & 48'hFFFF);
    endfunction

    // Reference model: each instance is a FIFO of capacity 2, accepting when fewer than 2 are held
    // (as seen before the edge) and delivering the oldest beat when downstream is ready.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q4.delete();
            q3.delete();
        end else begin
            bit acc4, pop4, acc3, pop3;
            acc4 = in_valid && (q4.size() < 2);
            pop4 = (q4.size() > 0) && out_ready;
            acc3 = in_valid && (q3.size() < 2);
            pop3 = (q3.size() > 0) && out_ready;
            if (pop4) void'(q4.pop_front());
            if (pop3) void'(q3.pop_front());
            if (acc4) q4.push_back('{d: ref4(din, sel), e: 1'b0});
            if (acc3) q3.push_back('{d: ref3(din3, sel), e: ERR_EN && (sel >= 2'd3)});
        end
    end

    task automatic test_reset;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
        checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid3: got %b expected 0", out_valid3); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_streaming;
        logic [31:0] exp_s [4];
        exp_s = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD};
        din = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sel = 2'(k);
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (out_data !== exp_s[k]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", k, out_data, exp_s[k]); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0; sel = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_data !== 32'hBBBB) begin errors++; $display("FAIL bp_first: got %h expected bbbb", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
        @(negedge clk);
        sel = 2'd2;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", in_ready); end
        checks++; if (out_data !== 32'hBBBB) begin errors++; $display("FAIL bp_hold: got %h expected bbbb", out_data); end
        @(negedge clk);
        sel = 2'd3;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_third: got %b expected 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_data !== 32'hCCCC) begin errors++; $display("FAIL bp_second_out: got %h expected cccc", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_third: got %b expected 0", out_valid); end
    endtask

    task automatic test_accept_pop;
        @(negedge clk);
        out_ready = 1'b0; sel = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_data !== 32'hAAAA) begin errors++; $display("FAIL ap_head: got %h expected aaaa", out_data); end
        @(negedge clk);
        out_ready = 1'b1; sel = 2'd3;
        @(posedge clk); #1;
        checks++; if (out_data !== 32'hDDDD) begin errors++; $display("FAIL ap_replace: got %h expected dddd", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ap_no_bubble: got %b expected 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ap_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_range;
        din3 = {16'h3333, 16'h2222, 16'h1111};
        @(negedge clk);
        out_ready = 1'b1; sel = 2'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid3 !== 1'b1) begin errors++; $display("FAIL range_valid: got %b expected 1", out_valid3); end
        checks++; if (out_data3 !== 16'h0) begin errors++; $display("FAIL range_data: got %h expected 0", out_data3); end
        checks++; if (sel_err3 !== ERR_EN) begin errors++; $display("FAIL range_err: got %b expected %b", sel_err3, ERR_EN); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL range_err4: got %b expected 0", sel_err); end
        @(negedge clk);
        sel = 2'd0;
        @(posedge clk); #1;
        checks++; if (out_data3 !== 16'h1111) begin errors++; $display("FAIL range_next_data: got %h expected 1111", out_data3); end
        checks++; if (sel_err3 !== 1'b0) begin errors++; $display("FAIL range_next_err: got %b expected 0", sel_err3); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        out_ready = 1'b0; sel = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        sel = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", in_ready); end
        #1 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
        checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL mid_out_valid3: got %b expected 0", out_valid3); end
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_first_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'hCCCC) begin errors++; $display("FAIL mid_first_data: got %h expected cccc", out_data); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stress;
        int pv, pr;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            checks++; if (out_valid !== (q4.size() > 0)) begin errors++; $display("FAIL st_valid4 @%0d: got %b expected %b", n, out_valid, q4.size() > 0); end
            checks++; if (in_ready !== (q4.size() < 2)) begin errors++; $display("FAIL st_ready4 @%0d: got %b expected %b", n, in_ready, q4.size() < 2); end
            checks++; if (out_valid3 !== (q3.size() > 0)) begin errors++; $display("FAIL st_valid3 @%0d: got %b expected %b", n, out_valid3, q3.size() > 0); end
            if (q4.size() > 0) begin
                checks++; if (out_data !== q4[0].d) begin errors++; $display("FAIL st_data4 @%0d: got %h expected %h", n, out_data, q4[0].d); end
                checks++; if (sel_err !== q4[0].e) begin errors++; $display("FAIL st_err4 @%0d: got %b expected %b", n, sel_err, q4[0].e); end
            end
            if (q3.size() > 0) begin
                checks++; if (out_data3 !== q3[0].d[15:0]) begin errors++; $display("FAIL st_data3 @%0d: got %h expected %h", n, out_data3, q3[0].d[15:0]); end
                checks++; if (sel_err3 !== q3[0].e) begin errors++; $display("FAIL st_err3 @%0d: got %b expected %b", n, sel_err3, q3[0].e); end
            end
            pv = 20 + 30 * ((n / 1000) % 3);
            pr = 80 - 30 * ((n / 700) % 3);
            in_valid  = ($urandom % 100) < pv;
            out_ready = ($urandom % 100) < pr;
            sel  = 2'($urandom_range(0, 3));
            din  = {$urandom, $urandom, $urandom, $urandom};
            din3 = {16'($urandom), 16'($urandom), 16'($urandom)};
            #1;
            checks++; if (in_ready !== (q4.size() < 2)) begin errors++; $display("FAIL st_ready_indep @%0d: got %b expected %b", n, in_ready, q4.size() < 2); end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        din = '0; din3 = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset;
        test_streaming;
        test_backpressure;
        test_accept_pop;
        test_range;
        test_reset_midstream;
        test_stress;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
